// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared constants for the writeback arbiter
package regfile_wb_arbiter_pkg;

    localparam int NREQ = 3;
    localparam int DW   = 32;
    localparam int AW   = 5;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_MDU = 2;

    localparam logic [AW-1:0] ZERO_REG = '0;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// rtl/regfile_wb_arbiter_rr.sv - round-robin arbiter with one-hot grant
module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] grant_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] idx;
    logic          found;

    // Search upward from the pointer; the winner's successor becomes the new pointer.
    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(ptr_q) + k) % NREQ);
            if (!found && !rst && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
                ptr_d        = PW'((int'(idx) + 1) % NREQ);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register-file write port and tracks pending writes
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREQ = regfile_wb_arbiter_pkg::NREQ,
    parameter int DW   = regfile_wb_arbiter_pkg::DW,
    parameter int AW   = regfile_wb_arbiter_pkg::AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic               rf_we,
    output logic [AW-1:0]      rf_waddr,
    output logic [DW-1:0]      rf_wdata,
    input  logic               sb_set,
    input  logic [AW-1:0]      sb_set_addr,
    input  logic [AW-1:0]      rs_addr,
    input  logic [AW-1:0]      rt_addr,
    output logic               rs_busy,
    output logic               rt_busy
);

    localparam int NREG = 1 << AW;

    logic [NREQ-1:0] grant;
    logic            any_grant;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    logic            we_q,    we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [NREG-1:0] sb_q,    sb_d;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req_valid),
        .grant_o (grant)
    );

    assign req_ready = grant;
    assign any_grant = |grant;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = sel_addr | req_addr[i*AW +: AW];
                sel_data = sel_data | req_data[i*DW +: DW];
            end
        end
    end

    // Writes to register 0 still handshake but never reach the register file.
    always_comb begin
        we_d    = any_grant && (sel_addr != AW'(ZERO_REG));
        waddr_d = any_grant ? sel_addr : waddr_q;
        wdata_d = any_grant ? sel_data : wdata_q;
    end

    // Clear is applied before set so a newer producer keeps the register busy.
    always_comb begin
        sb_d = sb_q;
        if (we_q) begin
            sb_d[waddr_q] = 1'b0;
        end
        if (sb_set) begin
            sb_d[sb_set_addr] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            sb_q    <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            sb_q    <= sb_d;
        end
    end

    assign rf_we    = we_q;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;
    assign rs_busy  = sb_q[rs_addr];
    assign rt_busy  = sb_q[rt_addr];

endmodule
